// File: rtl/clk_pkg.sv
// Shared clock-block definitions: divisor limits, the divider state encoding and
// a default divisor type for clock blocks built around an 8-bit divisor.
package clk_pkg;

    localparam int DIV_MIN       = 2;
    localparam int CLK_DIV_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [CLK_DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/clk_div.sv
// Programmable integer clock divider with a registered, glitch-free output and a
// source-domain tick; divisor and enable changes take effect only at period boundaries.
//
// state | meaning
// IDLE  | clk_o held low, cnt parked at N-1, every edge is a period boundary
// RUN   | cnt walks 0..N-1, clk_o high while cnt < ceil(N/2)
module clk_div
    import clk_pkg::*;
#(
    parameter int DIV_WIDTH = CLK_DIV_WIDTH,
    parameter int RESET_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_err_o,
    output logic [DIV_WIDTH-1:0] cur_div_o,
    output logic                 clk_o,
    output logic                 tick_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_MIN_W   = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] RESET_DIV_W = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE         = DIV_WIDTH'(1);

    logic                 pending;
    logic [DIV_WIDTH-1:0] pend_div;
    logic                 ready_q;
    logic                 err_q;

    state_e               state, state_nxt;
    logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [DIV_WIDTH-1:0] cur_div, cur_div_nxt;
    logic                 clk_q, clk_nxt;
    logic                 tick_q, tick_nxt;

    logic [DIV_WIDTH-1:0] half;
    logic                 boundary;
    logic                 xfer;
    logic                 legal;

    // ceil(N/2) without widening: N>>1 plus the dropped LSB
    assign half     = (cur_div >> 1) + {{(DIV_WIDTH-1){1'b0}}, cur_div[0]};
    assign boundary = (state == IDLE) || (cnt == cur_div - ONE);
    assign xfer     = div_valid_i && ready_q;
    assign legal    = (div_i >= DIV_MIN_W);

    // Handshake: ready is registered so it returns one cycle after the applying boundary
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pending  <= 1'b0;
            pend_div <= RESET_DIV_W;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q   <= xfer && !legal;
            ready_q <= !(pending || (xfer && legal));
            if (xfer && legal) begin
                pending  <= 1'b1;
                pend_div <= div_i;
            end else if (boundary) begin
                pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= IDLE;
            cnt     <= RESET_DIV_W - ONE;
            cur_div <= RESET_DIV_W;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_div <= cur_div_nxt;
            clk_q   <= clk_nxt;
            tick_q  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_div_nxt = cur_div;
        clk_nxt     = clk_q;
        tick_nxt    = 1'b0;
        if (boundary) begin
            if (pending) begin
                cur_div_nxt = pend_div;
            end
            if (en_i) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
                clk_nxt   = 1'b1;
                tick_nxt  = 1'b1;
            end else begin
                // park at N-1 of the divisor now in effect so the next start is a clean boundary
                state_nxt = IDLE;
                cnt_nxt   = cur_div_nxt - ONE;
                clk_nxt   = 1'b0;
            end
        end else begin
            cnt_nxt = cnt + ONE;
            clk_nxt = (cnt_nxt < half);
        end
    end

    assign div_ready_o = ready_q;
    assign div_err_o   = err_q;
    assign cur_div_o   = cur_div;
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;

endmodule

// File: doc/clk_div.md
Name: clk_div

Overview:
Programmable integer clock divider placed directly downstream of the glitch-free clock mux; its clk_i is the muxed clock output.
- Produces a registered, glitch-free divided clock plus a one-cycle tick in the source domain.
- The divisor is changed at runtime through a valid/ready handshake. A change is applied only at a period boundary, so clk_o never produces a runt pulse.
- A run enable starts and stops the output cleanly, always on a period boundary.

Parameters:
DIV_WIDTH, 8, width of divisor fields; legal divisors are 2 to 2^DIV_WIDTH-1.
RESET_DIV, 2, divisor active after reset; must be legal (2 to 2^DIV_WIDTH-1).

Ports:
clk_i  input  1  source clock (muxed clock).
arst_ni  input  1  reset; asynchronous assert, active low.
en_i  input  1  run enable; sampled only at period boundaries.
div_i  input  DIV_WIDTH  requested divisor.
div_valid_i  input  1  div_i valid.
div_ready_o  output  1  high when no update is pending.
div_err_o  output  1  one-cycle pulse when an illegal divisor is accepted.
cur_div_o  output  DIV_WIDTH  divisor currently in effect.
clk_o  output  1  divided clock, driven directly from a flop.
tick_o  output  1  one clk_i cycle pulse coincident with each clk_o rising edge.

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_ni is asynchronous, active low.
- Reset values:
  - clk_o=0, tick_o=0, div_err_o=0, div_ready_o=1.
  - cur_div_o=RESET_DIV, cnt=RESET_DIV-1.
  - Pending flag=0; state=IDLE.
  - Reset asserted mid-period forces clk_o low immediately (asynchronously).
- Notation: N = cur_div, H = (N+1)>>1, the number of high cycles. Odd N gives high one cycle longer than low (N=5: 3 high, 2 low).
- States:
  - IDLE: clk_o=0; cnt held at N-1. Every edge is a boundary.
  - RUN: counting.
- Counter (RUN only): cnt advances 0..N-1 and wraps. clk_o_next = (cnt_next < H).
- Boundary edge = any edge in IDLE, or any edge in RUN with cnt==N-1. At a boundary, in order:
  1. If pending, N <= pending divisor and pending is cleared.
  2. If en_i=1: cnt<=0, clk_o<=1, tick_o<=1, state=RUN.
  3. If en_i=0: clk_o<=0, cnt<=N-1 (using the new N), state=IDLE.
- Stop behaviour: deasserting en_i mid-period always completes the current full period; there is no truncated high or low phase.
- Start latency: en_i sampled high in IDLE gives clk_o=1 and tick_o=1 after that same edge, i.e. 1 clk_i cycle.
- Divisor update handshake:
  - Transfer occurs on an edge with div_valid_i & div_ready_o.
  - Legal div_i: latched as pending; div_ready_o=0 until the boundary that applies it, then 1 on the following cycle.
  - Illegal div_i (<2): not latched. div_err_o pulses for 1 cycle after the transfer; div_ready_o stays 1; N is unchanged.
- Simultaneous events:
  - A transfer on a boundary edge is stored as pending and applied at the next boundary, not the current one.
  - In IDLE that is the next edge; ready therefore returns after 2 cycles.
- Value changes:
  - cur_div_o changes only at boundaries.
  - Writing a value equal to N still performs a full handshake.
- Width: all counter and compare arithmetic is DIV_WIDTH bits. H is computed without overflow (N ≤ 2^DIV_WIDTH-1).
- Duty-cycle examples:
  - N=2: clk_o toggles every edge.
  - N=2^DIV_WIDTH-1: high 2^(DIV_WIDTH-1) cycles.

Decomposition:
- Shared clock package (clk_pkg):
  - Constant DIV_MIN=2.
  - Typedef for the state enum {IDLE, RUN}.
  - Divisor typedef parameterised by DIV_WIDTH, reused by future clock blocks.
- No sub-module required. The handshake/pending register and the counter/output FSM are two always_ff blocks in one module.

Test Plan:
- Reset, en_i=1, RESET_DIV=2 -> first edge clk_o=1 & tick_o=1; then clk_o period 2 cycles, 50% duty, tick_o every 2 cycles.
- Running N=4, write div_i=5 at cnt=1 -> ready_o=0; current N=4 period completes; next period clk_o high 3 / low 2; cur_div_o=5 at that boundary; ready_o=1 one cycle later.
- Write div_i=1 (and separately 0) -> div_err_o 1-cycle pulse; ready_o stays 1; cur_div_o and period unchanged.
- N=3 running, drop en_i at cnt=0 -> clk_o finishes high 2 / low 1, then stays 0; tick_o silent. Raise en_i -> clk_o=1 after 1 cycle.
- IDLE, write div_i=6 -> cur_div_o=6 on the next edge, ready_o=1 the cycle after. Then enable -> high 3 / low 3.
- Assert arst_ni while clk_o=1 mid-period -> clk_o=0 immediately; all outputs at reset values; operation resumes correctly after release.
